axi_fourchan_slave_wr_sequencer: RTL and testbench

- Write-path controller on the slave side of the four-channel AXI logic link.
- Sits between the AW/W logic-link receive FIFOs and the user AXI slave AW/W channels.
- Gates AW acceptance against an outstanding-write limit and releases W beats only for bursts whose AW has already been accepted.
- Counts W beats against AWLEN, flags WLAST mismatches, and tracks B returns to retire outstanding writes.

---
 rtl/axi_fourchan_slave_wr_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_axi_fourchan_slave_wr_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_fourchan_slave_wr_sequencer.sv
// Purpose: slave-side AXI write sequencer; gates AW on an outstanding limit, releases W only for accepted bursts, checks WLAST and tracks B retirement.
// Latency: 0 cycles on all AW/W gates; outstanding_cnt and error flags update 1 cycle after the handshake.
// Backpressure: AW stalls at the outstanding limit or when the AWLEN FIFO is full; W stalls while no burst has been accepted.
//
// Ports:
//   clk_wr, rst_wr_n             clock, async active-low reset
//   rx_aw_vld/rx_aw_ready/rx_awlen  AW side of the link receive FIFO
//   user_awvalid/user_awready    AW handshake with the user slave
//   rx_w_vld/rx_w_ready/rx_wlast W side of the link receive FIFO
//   user_wvalid/user_wready      W handshake with the user slave
//   user_bvalid/user_b_ready     B handshake, observed only
//   err_clr                      clears the sticky error flags
//   outstanding_cnt, wlast_err, b_underflow_err  status

// Small circular FIFO holding the AWLEN of every accepted burst.
// Latency: head visible the cycle after the first push; no bypass.
// Backpressure: caller must not push while full or pop while empty.
module axi_fourchan_slave_wr_sequencer_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] head_dat,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    // Pointers wrap modulo DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign head_dat = mem[rd_ptr];
    assign full     = (occ == DEPTH_OCC);
    assign empty    = (occ == '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

module axi_fourchan_slave_wr_sequencer #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk_wr,
    input  logic             rst_wr_n,
    input  logic             rx_aw_vld,
    output logic             rx_aw_ready,
    input  logic [7:0]       rx_awlen,
    output logic             user_awvalid,
    input  logic             user_awready,
    input  logic             rx_w_vld,
    output logic             rx_w_ready,
    input  logic             rx_wlast,
    output logic             user_wvalid,
    input  logic             user_wready,
    input  logic             user_bvalid,
    input  logic             user_b_ready,
    input  logic             err_clr,
    output logic [CNT_W-1:0] outstanding_cnt,
    output logic             wlast_err,
    output logic             b_underflow_err
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    logic             aw_ok;
    logic             w_ok;
    logic             aw_hs;
    logic             w_hs;
    logic             b_hs;
    logic             fifo_full;
    logic             fifo_empty;
    logic             burst_end;
    logic [7:0]       head_len;
    logic [7:0]       beat_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             b_uf_set;
    logic             wlast_set;

    assign aw_ok        = (outstanding_cnt < MAX_CNT) && !fifo_full;
    assign user_awvalid = rx_aw_vld & aw_ok;
    assign rx_aw_ready  = user_awready & aw_ok;
    assign aw_hs        = user_awvalid & user_awready;

    // No bypass: a burst's W beats wait until its AWLEN is in the FIFO.
    assign w_ok         = !fifo_empty;
    assign user_wvalid  = rx_w_vld & w_ok;
    assign rx_w_ready   = user_wready & w_ok;
    assign w_hs         = user_wvalid & user_wready;

    assign b_hs         = user_bvalid & user_b_ready;

    // Burst boundaries come from AWLEN; WLAST is only checked against them.
    assign burst_end    = w_hs && (beat_cnt == head_len);
    assign wlast_set    = w_hs && (burst_end ? !rx_wlast : rx_wlast);

    axi_fourchan_slave_wr_sequencer_fifo #(
        .WIDTH (8),
        .DEPTH (MAX_OUTSTANDING)
    ) u_awlen_fifo (
        .clk      (clk_wr),
        .rst_n    (rst_wr_n),
        .push     (aw_hs),
        .push_dat (rx_awlen),
        .pop      (burst_end),
        .head_dat (head_len),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // An AW and a B in the same cycle cancel, except at zero where the B
    // has nothing to retire yet and is absorbed without an error.
    always_comb begin
        cnt_nxt  = outstanding_cnt;
        b_uf_set = 1'b0;
        case ({aw_hs, b_hs})
            2'b10: cnt_nxt = outstanding_cnt + 1'b1;
            2'b01: begin
                if (outstanding_cnt != '0) begin
                    cnt_nxt = outstanding_cnt - 1'b1;
                end else begin
                    b_uf_set = 1'b1;
                end
            end
            2'b11: begin
                if (outstanding_cnt == '0) begin
                    cnt_nxt = CNT_W'(1);
                end
            end
            default: cnt_nxt = outstanding_cnt;
        endcase
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            outstanding_cnt <= '0;
            beat_cnt        <= '0;
            wlast_err       <= 1'b0;
            b_underflow_err <= 1'b0;
        end else begin
            outstanding_cnt <= cnt_nxt;
            if (burst_end) begin
                beat_cnt <= '0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            // A new error in the clearing cycle wins over err_clr.
            wlast_err       <= wlast_set | (wlast_err & ~err_clr);
            b_underflow_err <= b_uf_set  | (b_underflow_err & ~err_clr);
        end
    end
endmodule

// File: tb/tb_axi_fourchan_slave_wr_sequencer.sv
module tb_axi_fourchan_slave_wr_sequencer;
    localparam int MAXO  = 8;
    localparam int CNT_W = $clog2(MAXO + 1);

    logic             clk_wr = 1'b0;
    logic             rst_wr_n = 1'b0;
    logic             rx_aw_vld = 1'b0;
    logic             rx_aw_ready;
    logic [7:0]       rx_awlen = 8'd0;
    logic             user_awvalid;
    logic             user_awready = 1'b0;
    logic             rx_w_vld = 1'b0;
    logic             rx_w_ready;
    logic             rx_wlast = 1'b0;
    logic             user_wvalid;
    logic             user_wready = 1'b0;
    logic             user_bvalid = 1'b0;
    logic             user_b_ready = 1'b0;
    logic             err_clr = 1'b0;
    logic [CNT_W-1:0] outstanding_cnt;
    logic             wlast_err;
    logic             b_underflow_err;

    axi_fourchan_slave_wr_sequencer #(.MAX_OUTSTANDING(MAXO)) dut (
        .clk_wr          (clk_wr),
        .rst_wr_n        (rst_wr_n),
        .rx_aw_vld       (rx_aw_vld),
        .rx_aw_ready     (rx_aw_ready),
        .rx_awlen        (rx_awlen),
        .user_awvalid    (user_awvalid),
        .user_awready    (user_awready),
        .rx_w_vld        (rx_w_vld),
        .rx_w_ready      (rx_w_ready),
        .rx_wlast        (rx_wlast),
        .user_wvalid     (user_wvalid),
        .user_wready     (user_wready),
        .user_bvalid     (user_bvalid),
        .user_b_ready    (user_b_ready),
        .err_clr         (err_clr),
        .outstanding_cnt (outstanding_cnt),
        .wlast_err       (wlast_err),
        .b_underflow_err (b_underflow_err)
    );

    always #5 clk_wr = ~clk_wr;

    typedef struct {
        bit awv;
        bit awr;
        bit wv;
        bit wr;
        int cnt;
        bit wle;
        bit bue;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the list of accepted burst lengths still owed data,
    // the beat index inside the head burst, and the outstanding write count.
    int   mq[$];
    int   beat = 0;
    int   outst = 0;
    bit   wle = 1'b0;
    bit   bue = 1'b0;
    int   aw_acc = 0;
    int   exp_beats = 0;
    int   w_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk_wr) begin
        if (rst_wr_n) begin
            if (user_wvalid && user_wready) w_seen++;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("user_awvalid", int'(user_awvalid), int'(e.awv));
                chk("rx_aw_ready", int'(rx_aw_ready), int'(e.awr));
                chk("user_wvalid", int'(user_wvalid), int'(e.wv));
                chk("rx_w_ready", int'(rx_w_ready), int'(e.wr));
                chk("outstanding_cnt", int'(outstanding_cnt), e.cnt);
                chk("wlast_err", int'(wlast_err), int'(e.wle));
                chk("b_underflow_err", int'(b_underflow_err), int'(e.bue));
            end
        end
    end

    // Drive one cycle, queue what the DUT must show, then advance the model.
    task automatic cyc(input bit awv, input int len, input bit awr, input bit wv,
                       input bit wl, input bit wr, input bit bv, input bit br, input bit clr);
        exp_t e;
        bit aw_ok, w_ok, aw_hs, w_hs, b_hs, wl_set, bu_set;
        rx_aw_vld = awv; rx_awlen = 8'(len); user_awready = awr;
        rx_w_vld = wv; rx_wlast = wl; user_wready = wr;
        user_bvalid = bv; user_b_ready = br; err_clr = clr;
        aw_ok = (outst < MAXO) && (mq.size() < MAXO);
        w_ok  = (mq.size() != 0);
        e.awv = awv && aw_ok;
        e.awr = awr && aw_ok;
        e.wv  = wv && w_ok;
        e.wr  = wr && w_ok;
        e.cnt = outst;
        e.wle = wle;
        e.bue = bue;
        exp_q.push_back(e);
        aw_hs = awv && awr && aw_ok;
        w_hs  = wv && wr && w_ok;
        b_hs  = bv && br;
        wl_set = 1'b0;
        bu_set = 1'b0;
        if (w_hs) begin
            if (beat == mq[0]) begin
                mq.delete(0);
                beat = 0;
                wl_set = !wl;
            end else begin
                beat++;
                wl_set = wl;
            end
        end
        if (aw_hs) begin
            mq.push_back(len);
            aw_acc++;
            exp_beats += len + 1;
        end
        if (aw_hs && b_hs) begin
            if (outst == 0) outst = 1;
        end else if (aw_hs) begin
            outst++;
        end else if (b_hs) begin
            if (outst > 0) outst--;
            else bu_set = 1'b1;
        end
        wle = wl_set || (wle && !clr);
        bue = bu_set || (bue && !clr);
        @(posedge clk_wr);
        #1;
    endtask

    task automatic idle_inputs();
        rx_aw_vld = 0; rx_awlen = 0; user_awready = 0; rx_w_vld = 0; rx_wlast = 0;
        user_wready = 0; user_bvalid = 0; user_b_ready = 0; err_clr = 0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_cnt"}, int'(outstanding_cnt), 0);
        chk({tag, "_wlast_err"}, int'(wlast_err), 0);
        chk({tag, "_b_uf_err"}, int'(b_underflow_err), 0);
        chk({tag, "_awvalid"}, int'(user_awvalid), 0);
        chk({tag, "_aw_ready"}, int'(rx_aw_ready), 0);
        chk({tag, "_wvalid"}, int'(user_wvalid), 0);
        chk({tag, "_w_ready"}, int'(rx_w_ready), 0);
    endtask

    initial begin
        bit done;
        bit wl;
        #12;
        check_reset_state("reset");
        @(negedge clk_wr);
        rst_wr_n = 1'b1;
        @(posedge clk_wr);
        #1;

        // Single write: W is held off in the AW cycle.
        cyc(1, 3, 1, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Outstanding limit: ninth AW waits for a retirement.
        for (int i = 0; i < 9; i++) cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 1, 1, 1, 1, 1, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 1, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // W before AW.
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
        cyc(1, 0, 1, 1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 1, 1, 0);

        // WLAST errors: early WLAST, then missing WLAST, then clear.
        cyc(1, 2, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 1);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Underflow, simultaneous AW+B at zero and at two.
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 1, 0, 0, 0, 1, 1, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 1, 1, 1, 0);
        cyc(0, 0, 0, 1, 1, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Random overlapping traffic, 20 bursts of 1..16 beats.
        aw_acc = 0;
        exp_beats = 0;
        w_seen = 0;
        done = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            if (aw_acc >= 20 && outst == 0 && mq.size() == 0) begin
                done = 1'b1;
            end else begin
                wl = (mq.size() > 0) ? (beat == mq[0]) : 1'($urandom);
                cyc((aw_acc < 20) && ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)),
                    $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, wl,
                    $urandom_range(0, 3) != 0, (outst > mq.size()) && ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 3) != 0, 0);
            end
        end
        if (!done) begin
            errors++;
            $display("FAIL random_phase_timeout: accepted %0d outstanding %0d, required drain", aw_acc, outst);
        end
        chk("beat_total", w_seen, exp_beats);

        // Asynchronous reset in the middle of a burst with errors pending.
        cyc(0, 0, 0, 0, 0, 0, 1, 1, 0);
        cyc(1, 5, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        cyc(0, 0, 0, 1, 0, 1, 0, 0, 0);
        idle_inputs();
        #2;
        rst_wr_n = 1'b0;
        #1;
        check_reset_state("midrst");
        mq.delete();
        beat = 0;
        outst = 0;
        wle = 1'b0;
        bue = 1'b0;
        @(negedge clk_wr);
        rst_wr_n = 1'b1;
        @(posedge clk_wr);
        #1;
        cyc(0, 0, 0, 1, 1, 1, 0, 0, 0);
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1, 1, 1, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
